// File: rtl/spin_readout_pkg.sv
// Shared types and constants for the Ising-machine spin readout block:
// FSM state encoding, configuration field layout and reset defaults.
package spin_readout_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam int WINDOW_LSB = 0;
    localparam int SETTLE_LSB = 16;

    localparam int DEF_WINDOW = 256;
    localparam int DEF_SETTLE = 64;

    localparam logic [31:0] CFG_RESET = (32'(DEF_SETTLE) << SETTLE_LSB)
                                      | (32'(DEF_WINDOW) << WINDOW_LSB);

endpackage

// File: rtl/spin_readout_sync.sv
// Parameterised-width two-flop synchronizer for asynchronous oscillator
// phase inputs; both stages clear on the asynchronous active-low reset.
module spin_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         ising_rstn,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q, meta_d;
    logic [W-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, regardless of block order.
    always_ff @(posedge clk or negedge ising_rstn) begin
        if (!ising_rstn) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/spin_readout.sv
// Spin readout: counts per-row phase mismatches against a reference over a
// configurable window after a settle delay, then latches majority decisions.
module spin_readout
    import spin_readout_pkg::*;
#(
    parameter int NUM_SPINS = 8,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 ising_rstn,
    input  logic                 axi_rstn,
    input  logic [NUM_SPINS-1:0] osc_in,
    input  logic                 ref_in,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [NUM_SPINS-1:0] spins,
    input  logic                 wready,
    input  logic                 wr_addr_match,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata
);

    logic [NUM_SPINS:0]   sync_out;
    logic [NUM_SPINS-1:0] osc_s;
    logic                 ref_s;

    spin_sync #(.W(NUM_SPINS + 1)) u_sync (
        .clk        (clk),
        .ising_rstn (ising_rstn),
        .d          ({ref_in, osc_in}),
        .q          (sync_out)
    );

    assign osc_s = sync_out[NUM_SPINS-1:0];
    assign ref_s = sync_out[NUM_SPINS];

    logic [31:0]      cfg_q, cfg_d;
    logic [CNT_W-1:0] cfg_window, cfg_settle, window_eff;

    always_comb begin
        cfg_d = cfg_q;
        if (!axi_rstn)
            cfg_d = CFG_RESET;
        else if (wready && wr_addr_match)
            cfg_d = wdata;
    end

    // Configuration lives in the AXI reset domain and survives ising_rstn.
    always_ff @(posedge clk) begin
        cfg_q <= cfg_d;
    end

    assign cfg_window = cfg_q[WINDOW_LSB +: CNT_W];
    assign cfg_settle = cfg_q[SETTLE_LSB +: CNT_W];
    assign window_eff = (cfg_window == '0) ? CNT_W'(1) : cfg_window;
    assign rdata      = cfg_q;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     settle_q, settle_d;
    logic [CNT_W-1:0]     win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0]     win_cap_q, win_cap_d;
    logic [CNT_W-1:0]     mis_q [NUM_SPINS];
    logic [CNT_W-1:0]     mis_d [NUM_SPINS];
    logic [NUM_SPINS-1:0] spins_q, spins_d;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        win_cnt_d = win_cnt_q;
        win_cap_d = win_cap_q;
        mis_d     = mis_q;
        spins_d   = spins_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    settle_d = cfg_settle;
                    for (int i = 0; i < NUM_SPINS; i++) mis_d[i] = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_q == '0) begin
                    win_cnt_d = window_eff;
                    win_cap_d = window_eff;
                    state_d   = MEASURE;
                end else begin
                    settle_d = settle_q - CNT_W'(1);
                end
            end
            MEASURE: begin
                for (int i = 0; i < NUM_SPINS; i++) begin
                    if ((osc_s[i] != ref_s) && (mis_q[i] != '1))
                        mis_d[i] = mis_q[i] + CNT_W'(1);
                end
                win_cnt_d = win_cnt_q - CNT_W'(1);
                if (win_cnt_q == CNT_W'(1)) state_d = DONE;
            end
            DONE: begin
                // Strict majority: a tie at exactly half the window reads as in-phase.
                for (int i = 0; i < NUM_SPINS; i++)
                    spins_d[i] = (mis_q[i] > (win_cap_q >> 1));
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the mismatch counters are a register array, not a RAM; they are
    // reset explicitly so an aborted run leaves no stale counts behind.
    always_ff @(posedge clk or negedge ising_rstn) begin
        if (!ising_rstn) begin
            state_q   <= IDLE;
            settle_q  <= '0;
            win_cnt_q <= '0;
            win_cap_q <= '0;
            spins_q   <= '0;
            for (int i = 0; i < NUM_SPINS; i++) mis_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            win_cnt_q <= win_cnt_d;
            win_cap_q <= win_cap_d;
            spins_q   <= spins_d;
            mis_q     <= mis_d;
        end
    end

    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);
    assign spins = spins_q;

endmodule

// File: tb/tb_spin_readout.sv
// Directed bench for spin_readout: reset state, in/anti-phase rows, majority
// tie, reset abort, start-while-busy with cfg write, and window=0 handling.
module tb_spin_readout;

    logic        clk = 1'b0;
    logic        ising_rstn, axi_rstn;
    logic [7:0]  osc_in;
    logic        ref_in, start;
    logic        busy, done;
    logic [7:0]  spins;
    logic        wready, wr_addr_match;
    logic [31:0] wdata, rdata;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    spin_readout #(.NUM_SPINS(8), .CNT_W(16)) dut (
        .clk           (clk),
        .ising_rstn    (ising_rstn),
        .axi_rstn      (axi_rstn),
        .osc_in        (osc_in),
        .ref_in        (ref_in),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .spins         (spins),
        .wready        (wready),
        .wr_addr_match (wr_addr_match),
        .wdata         (wdata),
        .rdata         (rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Inputs for the clock edge following this negedge; row 3 gets extra
    // mismatch on edges s+1 .. s+m, which land in the first m window cycles.
    task automatic drive(input int j, input int s, input int m, input logic [7:0] mask);
        logic [7:0] extra;
        extra  = ((j >= s + 1) && (j <= s + m)) ? 8'h08 : 8'h00;
        ref_in = j[0];
        osc_in = {8{j[0]}} ^ (mask | extra);
    endtask

    task automatic cfg_write(input logic [31:0] val);
        @(negedge clk);
        wready = 1'b1; wr_addr_match = 1'b1; wdata = val;
        @(negedge clk);
        wready = 1'b0; wr_addr_match = 1'b0;
    endtask

    task automatic run_meas(input string tag, input int s, input int w, input int m,
                            input logic [7:0] mask, input logic [7:0] exp_spins,
                            input int restart_j, input int wr_j, input logic [31:0] wr_val);
        int done_cnt, done_at;
        logic busy_early;
        done_cnt = 0; done_at = -1; busy_early = 1'b0;
        @(negedge clk);
        start = 1'b1;
        drive(1, s, m, mask);
        for (int j = 2; j <= s + w + 6; j++) begin
            @(negedge clk);
            if (j == 2) busy_early = busy;
            if (done) begin done_cnt++; done_at = j - 1; end
            start         = (j == restart_j);
            wready        = (j == wr_j);
            wr_addr_match = (j == wr_j);
            wdata         = wr_val;
            drive(j, s, m, mask);
        end
        check({tag, "_busy_early"}, 32'(busy_early), 32'd1);
        check({tag, "_done_cnt"},   32'(done_cnt),   32'd1);
        check({tag, "_done_at"},    32'(done_at),    32'(s + 2 + w));
        check({tag, "_busy_end"},   32'(busy),       32'd0);
        check({tag, "_spins"},      32'(spins),      32'(exp_spins));
    endtask

    initial begin
        int done_cnt;
        ising_rstn = 1'b0; axi_rstn = 1'b0; start = 1'b0;
        osc_in = '0; ref_in = 1'b0;
        wready = 1'b0; wr_addr_match = 1'b0; wdata = '0;

        repeat (3) @(negedge clk);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_done",  32'(done),  32'd0);
        check("rst_spins", 32'(spins), 32'd0);
        ising_rstn = 1'b1; axi_rstn = 1'b1;
        @(negedge clk);
        check("rst_rdata", rdata, 32'h0040_0100);

        // Abort: reset pulse mid-MEASURE must drop busy and never report.
        cfg_write(32'h0004_0010);
        @(negedge clk);
        osc_in = 8'hFF; ref_in = 1'b0; start = 1'b1;
        for (int j = 2; j <= 10; j++) begin
            @(negedge clk);
            start = 1'b0;
        end
        ising_rstn = 1'b0;
        #1;
        check("abort_busy_rst", 32'(busy), 32'd0);
        check("abort_done_rst", 32'(done), 32'd0);
        @(negedge clk);
        ising_rstn = 1'b1;
        done_cnt = 0;
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_spins",   32'(spins),    32'd0);
        check("abort_busy",    32'(busy),     32'd0);

        run_meas("inphase", 4, 16, 0, 8'h00, 8'h00, 0, 0, 32'h0);
        run_meas("anti",    4, 16, 0, 8'h81, 8'h81, 0, 0, 32'h0);
        run_meas("tie8",    4, 16, 8, 8'h00, 8'h00, 0, 0, 32'h0);
        run_meas("tie9",    4, 16, 9, 8'h00, 8'h08, 0, 0, 32'h0);

        // Restart and cfg write mid-MEASURE: threshold stays at 16>>1 = 8,
        // so row 3 with 2 mismatches reads 0 (new window 2 would give 1).
        run_meas("busy", 4, 16, 2, 8'h81, 8'h81, 12, 10, 32'h0000_0002);
        check("busy_rdata", rdata, 32'h0000_0002);
        repeat (5) @(negedge clk);
        check("spins_hold", 32'(spins), 32'h81);

        @(negedge clk);
        axi_rstn = 1'b0;
        @(negedge clk);
        axi_rstn = 1'b1;
        check("axi_rst_rdata", rdata, 32'h0040_0100);
        cfg_write(32'h0000_0000);
        check("cfg0_rdata", rdata, 32'h0000_0000);
        // window=0 acts as 1: one mismatch on row 0 beats threshold 0.
        run_meas("cfg0", 0, 1, 0, 8'h01, 8'h01, 0, 0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
